// File: rtl/seq_pkg.sv
// Shared definitions for the datapath sequencer: opcodes, ALU encoding,
// FSM states and trap causes.
package seq_pkg;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_AND  = 6'h02;
  localparam logic [5:0] OP_NOR  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_SLT  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h06;
  localparam logic [5:0] OP_SUBI = 6'h07;
  localparam logic [5:0] OP_ANDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h09;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_HALT = 6'h3F;

  // ALU operation encoding, shared with the datapath
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_NOR = 3'd3,
    ALU_OR  = 3'd4,
    ALU_SLT = 3'd5
  } alu_op_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    TRAP_NONE     = 2'd0,
    TRAP_ILLEGAL  = 2'd1,
    TRAP_OVERFLOW = 2'd2
  } trap_cause_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: splits a 32-bit instruction into
// datapath controls and flags halt / illegal encodings.
module instr_decode
  import seq_pkg::*;
#(
  parameter int RF_DEPTH = 4
) (
  input  logic [31:0] instr,
  output logic [2:0]  alu_op,
  output logic        src_imm,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  wr,
  output logic [15:0] imm,
  output logic        is_halt,
  output logic        illegal
);

  localparam logic [5:0] RF_LIMIT = 6'(RF_DEPTH);

  logic [5:0] opcode;
  logic [4:0] f_rs, f_rt, f_rd;

  assign opcode = instr[31:26];
  assign f_rs   = instr[25:21];
  assign f_rt   = instr[20:16];
  assign f_rd   = instr[15:11];

  function automatic logic reg_bad(input logic [4:0] idx);
    return {1'b0, idx} >= RF_LIMIT;
  endfunction

  always_comb begin
    alu_op  = ALU_ADD;
    src_imm = 1'b0;
    rs      = f_rs;
    rt      = 5'd0;
    wr      = 5'd0;
    imm     = instr[15:0];
    is_halt = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_NOR, OP_OR, OP_SLT: begin
        alu_op  = opcode[2:0];
        rt      = f_rt;
        wr      = f_rd;
        illegal = reg_bad(f_rs) || reg_bad(f_rt) || reg_bad(f_rd);
      end
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_SLTI: begin
        src_imm = 1'b1;
        wr      = f_rt;
        illegal = reg_bad(f_rs) || reg_bad(f_rt);
        case (opcode)
          OP_ADDI: alu_op = ALU_ADD;
          OP_SUBI: alu_op = ALU_SUB;
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          default: alu_op = ALU_SLT;
        endcase
      end
      OP_HALT: is_halt = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle control sequencer: byte-wise fetch, decode, exec and write-back
// for the 32-bit register/ALU datapath, with halt and trap states.
module datapath_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int RF_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            imem_rd,
  output logic [PC_W-1:0] imem_addr,
  input  logic [7:0]      imem_data,
  input  logic            imem_valid,
  output logic [2:0]      alu_op,
  output logic            src_imm,
  output logic [4:0]      rs_addr,
  output logic [4:0]      rt_addr,
  output logic [4:0]      wr_addr,
  output logic [15:0]     imm,
  input  logic            alu_overflow,
  output logic            rf_we,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            retire,
  output logic            halted,
  output logic [1:0]      trap_cause,
  output state_t          dbg_state
);

  state_t      state, state_nxt;
  logic [1:0]  byte_cnt;
  logic [31:0] instr;

  logic [2:0]  d_alu_op;
  logic        d_src_imm, d_halt, d_illegal;
  logic [4:0]  d_rs, d_rt, d_wr;
  logic [15:0] d_imm;

  logic fetch_acc;
  logic ovf_trap;

  instr_decode #(.RF_DEPTH(RF_DEPTH)) u_decode (
    .instr   (instr),
    .alu_op  (d_alu_op),
    .src_imm (d_src_imm),
    .rs      (d_rs),
    .rt      (d_rt),
    .wr      (d_wr),
    .imm     (d_imm),
    .is_halt (d_halt),
    .illegal (d_illegal)
  );

  // Fetch handshake: imem_rd is held through FETCH; a byte transfers on
  // any cycle where imem_rd && imem_valid, otherwise address and count hold.
  assign fetch_acc = (state == S_FETCH) && imem_valid;
  assign imem_addr = pc + PC_W'(byte_cnt);

  // Only add/sub forms can overflow; alu_op is already registered here.
  assign ovf_trap = (state == S_WB) && alu_overflow &&
                    ((alu_op == ALU_ADD) || (alu_op == ALU_SUB));

  assign busy      = (state != S_IDLE) && (state != S_HALT) && (state != S_TRAP);
  assign halted    = (state == S_HALT);
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    imem_rd   = 1'b0;
    rf_we     = 1'b0;
    retire    = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        imem_rd = 1'b1;
        if (imem_valid && (byte_cnt == 2'd3)) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (d_halt)         state_nxt = S_HALT;
        else if (d_illegal) state_nxt = S_TRAP;
        else                state_nxt = S_EXEC;
      end
      S_EXEC:   state_nxt = S_WB;
      S_WB: begin
        if (ovf_trap) begin
          state_nxt = S_TRAP;
        end else begin
          rf_we     = 1'b1;
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      default:  state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= '0;
      byte_cnt   <= 2'd0;
      instr      <= 32'd0;
      trap_cause <= 2'(TRAP_NONE);
      alu_op     <= 3'd0;
      src_imm    <= 1'b0;
      rs_addr    <= 5'd0;
      rt_addr    <= 5'd0;
      wr_addr    <= 5'd0;
      imm        <= 16'd0;
    end else begin
      state <= state_nxt;
      if ((state == S_IDLE) && start) byte_cnt <= 2'd0;
      if (fetch_acc) begin
        instr    <= {instr[23:0], imem_data};
        byte_cnt <= byte_cnt + 2'd1;
      end
      if ((state == S_DECODE) && (state_nxt == S_EXEC)) begin
        alu_op  <= d_alu_op;
        src_imm <= d_src_imm;
        rs_addr <= d_rs;
        rt_addr <= d_rt;
        wr_addr <= d_wr;
        imm     <= d_imm;
      end
      if ((state == S_DECODE) && !d_halt && d_illegal) trap_cause <= 2'(TRAP_ILLEGAL);
      if (ovf_trap) trap_cause <= 2'(TRAP_OVERFLOW);
      if (retire) pc <= pc + PC_W'(4);
    end
  end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Multi-cycle control sequencer for the 32-bit register/ALU datapath. It fetches each instruction as four big-endian bytes from the byte-wide instruction memory, decodes the 6-bit opcode, drives ALU-operation, operand-select and register-address controls into the datapath, and issues one register-file write strobe per retired instruction. Illegal opcodes, out-of-range register indices and arithmetic overflow stop the sequencer in a trap state.

## Interface
- PC_W, 8, program-counter width in bits; byte address; wraps mod 2^PC_W.
- RF_DEPTH, 4, implemented registers; any index ≥ RF_DEPTH is illegal.
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  level; sampled only in IDLE.
- imem_rd  out  1  byte-read request; held until imem_valid.
- imem_addr  out  PC_W  byte address = pc + byte_cnt.
- imem_data  in  8  byte; valid in the same cycle as imem_valid.
- imem_valid  in  1  byte accepted on a cycle with imem_rd && imem_valid.
- alu_op  out  3  0 add, 1 sub, 2 and, 3 nor, 4 or, 5 slt.
- src_imm  out  1  1 = operand B is zero-extended imm.
- rs_addr, rt_addr, wr_addr  out  5 each  register indices.
- imm  out  16  instruction[15:0].
- alu_overflow  in  1  carry/borrow out of the datapath's 33-bit add/sub.
- rf_we  out  1  single-cycle register-write strobe.
- pc  out  PC_W  address of the current instruction.
- busy  out  1  high outside IDLE, HALT and TRAP.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  high in HALT.
- trap_cause  out  2  0 none, 1 illegal, 2 overflow; valid in TRAP.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT, TRAP.
- IDLE: start=1 → FETCH with byte_cnt=0.
- FETCH: imem_rd=1. Each accepted byte is shifted into instr MSB-first: {b0,b1,b2,b3}. The accept at byte_cnt=3 → DECODE. No accept means stay, with address and byte_cnt held.
- DECODE:
  - Opcodes 0–5 are R-type: rs=[25:21], rt=[20:16], wr=[15:11], src_imm=0.
  - Opcodes 6–10 are I-type addi/subi/andi/ori/slti: rs=[25:21], wr=[20:16], src_imm=1, alu_op = opcode−6 for 6,7; and=2, or=4, slt=5 for 8, 9, 10.
  - Opcode 6'h3F → HALT.
  - Any other opcode → TRAP with cause 1.
  - Any used register index ≥ RF_DEPTH → TRAP with cause 1.
  - Otherwise → EXEC.
- EXEC: controls are held stable → WB.
- WB:
  - alu_overflow is sampled only for add, sub, addi and subi. If it is 1: rf_we stays 0, pc does not advance, next state is TRAP with cause 2.
  - Otherwise: rf_we=1, retire=1, pc ← pc+4 (mod 2^PC_W), → FETCH.
- HALT/TRAP: absorbing until reset. start is ignored; imem_rd=0; rf_we=0.
- Register 0 is an ordinary writable register.
- slt/slti compare unsigned.

## Timing
- Reset values:
  - State IDLE, pc=0, byte_cnt=0, instr=0.
  - imem_rd=0, rf_we=0, retire=0, busy=0, halted=0, trap_cause=0.
  - alu_op=0, src_imm=0, all address outputs 0, imm=0.
- Reset mid-operation, including the WB cycle, forces these values on that edge. No write is issued in the cycle after reset.
- Throughput with imem_valid tied to 1 is 7 cycles per instruction: 4 FETCH, 1 DECODE, 1 EXEC, 1 WB. Each stalled fetch cycle adds 1.
- The start→first imem_rd latency is 1 cycle.
- Decode outputs are registered. They become valid the cycle after DECODE and hold through WB.
- rf_we and retire are asserted in the same WB cycle. The datapath writes on that cycle's clock edge.
- pc wraps from 252 to 0 without a trap.
- Byte addresses pc+1 to pc+3 wrap mod 2^PC_W.

## Structure
- Shared package `seq_pkg` holds:
  - Opcode localparams, including OP_HALT=6'h3F.
  - The alu_op encoding (shared with the datapath).
  - The state enum.
  - The trap_cause encoding.
- Sub-module `instr_decode` is purely combinational: instr → alu_op, src_imm, rs/rt/wr, imm, is_halt, illegal. The sequencer FSM registers its outputs.

## Test plan
- Reset, start=1, imem_valid=1, ADD (op 0, rs=1, rt=2, rd=3) → imem_addr 0,1,2,3; rf_we pulses at cycle 7 with wr_addr=3, alu_op=0; pc becomes 4.
- ORI rs=1, rt=2, imm=16'h00F0 → src_imm=1, alu_op=4, wr_addr=2, imm=16'h00F0; retire at cycle 7.
- Stall test: imem_valid low for 2 cycles on byte 2 → imem_addr held at 2, instruction retires at cycle 9, instr assembled correctly.
- SUB with alu_overflow=1 in WB → no rf_we, pc stays, TRAP with trap_cause=2. start is then ignored until reset.
- Error cases:
  - Opcode 6'h0B → TRAP with cause 1.
  - ADD with rd=5 (RF_DEPTH=4) → TRAP with cause 1.
  - Opcode 6'h3F → halted=1, busy=0.
- Reset asserted during WB of an ADD → rf_we=0 on the next cycle, pc=0, state IDLE. Re-start refetches from address 0.
